md_sched: RTL and testbench

- Scheduler for the single shared multiply/divide unit, used by both execute pipes of the dual-issue core (pipe 0 = older slot, pipe 1 = younger slot).
- Arbitrates requests and sequences a fixed-latency multiply or a 32-step iterative divide.
- Holds the HI/LO result until the consuming stage accepts it.
- Pipeline flush cancels any operation in flight.

---
 rtl/md_sched_pkg.sv | 41 ++++
 rtl/md_div_iter.sv | 91 +++++++++
 rtl/md_sched.sv | 171 +++++++++++++++++
 tb/tb_md_sched.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/md_sched_pkg.sv
// Shared types and constants for the multiply/divide scheduler.
package md_sched_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned DIV_ITERS = 32;
  localparam int unsigned CNT_W     = 6;

  typedef enum logic [1:0] {
    MD_OP_MULT  = 2'b00,
    MD_OP_MULTU = 2'b01,
    MD_OP_DIV   = 2'b10,
    MD_OP_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_ST_IDLE = 2'b00,
    MD_ST_MUL  = 2'b01,
    MD_ST_DIV  = 2'b10,
    MD_ST_DONE = 2'b11
  } md_state_e;

  typedef struct packed {
    md_op_e            op;
    logic              id;
    logic [XLEN-1:0]   src1;
    logic [XLEN-1:0]   src2;
  } md_req_t;

  function automatic logic md_is_div(input md_op_e op);
    return op[1];
  endfunction

  function automatic logic md_is_signed(input md_op_e op);
    return ~op[0];
  endfunction

  function automatic logic [XLEN-1:0] md_abs(input logic [XLEN-1:0] x, input logic sgn);
    return (sgn & x[XLEN-1]) ? (~x + XLEN'(1)) : x;
  endfunction

endpackage

// File: rtl/md_div_iter.sv
// Restoring divider: setup on start, then one quotient bit per cycle, sign-fixed
// result presented combinationally during the final iteration.
module md_div_iter
  import md_sched_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            is_signed,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done_c,
  output logic [XLEN-1:0] quotient_c,
  output logic [XLEN-1:0] remainder_c
);

  localparam int unsigned ITER_W = $clog2(DIV_ITERS);

  logic              active_q, active_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   dvsr_q, dvsr_d;
  logic              negq_q, negq_d;
  logic              negr_q, negr_d;

  logic [XLEN:0]     rem_sh;
  logic [XLEN:0]     diff;
  logic              take;
  logic [XLEN-1:0]   rem_nx;
  logic [XLEN-1:0]   quo_nx;

  // quo_q shifts the dividend out from the top while quotient bits enter below
  always_comb begin
    rem_sh = {rem_q, quo_q[XLEN-1]};
    diff   = rem_sh - {1'b0, dvsr_q};
    take   = ~diff[XLEN];
    rem_nx = take ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    quo_nx = {quo_q[XLEN-2:0], take};
  end

  assign done_c      = active_q & (iter_q == ITER_W'(DIV_ITERS - 1));
  assign quotient_c  = negq_q ? (~quo_nx + XLEN'(1)) : quo_nx;
  assign remainder_c = negr_q ? (~rem_nx + XLEN'(1)) : rem_nx;

  always_comb begin
    active_d = active_q;
    iter_d   = iter_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    if (start) begin
      active_d = 1'b1;
      iter_d   = '0;
      rem_d    = '0;
      quo_d    = md_abs(a, is_signed);
      dvsr_d   = md_abs(b, is_signed);
      // divide-by-zero keeps an all-ones quotient regardless of operand signs
      negq_d   = is_signed & (a[XLEN-1] ^ b[XLEN-1]) & (|b);
      negr_d   = is_signed & a[XLEN-1];
    end else if (active_q) begin
      rem_d  = rem_nx;
      quo_d  = quo_nx;
      iter_d = iter_q + ITER_W'(1);
      if (done_c) active_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= 1'b0;
      iter_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
    end else begin
      active_q <= active_d;
      iter_q   <= iter_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
    end
  end

endmodule

// File: rtl/md_sched.sv
// Shared multiply/divide scheduler for both execute pipes: arbitration,
// fixed-latency multiply, iterative divide and result hold until accepted.
module md_sched
  import md_sched_pkg::*;
#(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [1:0]        req_valid,
  input  logic [3:0]        req_op,
  input  logic [2*XLEN-1:0] req_src1,
  input  logic [2*XLEN-1:0] req_src2,
  output logic [1:0]        req_ready,
  output logic              busy,
  output logic              resp_valid,
  output logic              resp_id,
  output logic [XLEN-1:0]   resp_hi,
  output logic [XLEN-1:0]   resp_lo,
  input  logic              resp_ready
);

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  md_req_t           req_q, req_d;
  logic              busy_q, busy_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_id_q, resp_id_d;
  logic [XLEN-1:0]   resp_hi_q, resp_hi_d;
  logic [XLEN-1:0]   resp_lo_q, resp_lo_d;

  logic              idle;
  logic              fire;
  logic              fire_id;
  md_req_t           sel_req;
  md_req_t           mul_req;
  logic [2*XLEN-1:0] mul_a;
  logic [2*XLEN-1:0] mul_b;
  logic [2*XLEN-1:0] product;
  logic              div_start;
  logic              div_signed;
  logic              div_kill;
  logic              div_done_c;
  logic [XLEN-1:0]   div_quo_c;
  logic [XLEN-1:0]   div_rem_c;

  // pipe 0 always wins; nothing is granted outside IDLE or during a flush
  assign idle      = (state_q == MD_ST_IDLE);
  assign req_ready = {req_valid[1] & ~req_valid[0] & ~flush & idle,
                      req_valid[0] & ~flush & idle};
  assign fire      = |(req_valid & req_ready);
  assign fire_id   = ~req_ready[0];

  always_comb begin
    sel_req.op   = md_op_e'(fire_id ? req_op[3:2] : req_op[1:0]);
    sel_req.id   = fire_id;
    sel_req.src1 = fire_id ? req_src1[2*XLEN-1:XLEN] : req_src1[XLEN-1:0];
    sel_req.src2 = fire_id ? req_src2[2*XLEN-1:XLEN] : req_src2[XLEN-1:0];
  end

  // single multiplier fed from the live request only when MUL_LAT is 1
  always_comb begin
    mul_req = idle ? sel_req : req_q;
    mul_a   = {{XLEN{md_is_signed(mul_req.op) & mul_req.src1[XLEN-1]}}, mul_req.src1};
    mul_b   = {{XLEN{md_is_signed(mul_req.op) & mul_req.src2[XLEN-1]}}, mul_req.src2};
    product = mul_a * mul_b;
  end

  assign div_start  = fire & md_is_div(sel_req.op);
  assign div_signed = md_is_signed(sel_req.op);
  assign div_kill   = reset | flush;

  md_div_iter u_div (
    .clk         (clk),
    .reset       (div_kill),
    .start       (div_start),
    .is_signed   (div_signed),
    .a           (sel_req.src1),
    .b           (sel_req.src2),
    .done_c      (div_done_c),
    .quotient_c  (div_quo_c),
    .remainder_c (div_rem_c)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    resp_id_d = resp_id_q;
    resp_hi_d = resp_hi_q;
    resp_lo_d = resp_lo_q;
    unique case (state_q)
      MD_ST_IDLE: begin
        if (fire) begin
          req_d = sel_req;
          cnt_d = '0;
          if (md_is_div(sel_req.op)) begin
            state_d = MD_ST_DIV;
          end else if (MUL_LAT == 1) begin
            state_d                = MD_ST_DONE;
            resp_id_d              = sel_req.id;
            {resp_hi_d, resp_lo_d} = product;
          end else begin
            state_d = MD_ST_MUL;
          end
        end
      end
      MD_ST_MUL: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(MUL_LAT - 2)) begin
          state_d                = MD_ST_DONE;
          resp_id_d              = req_q.id;
          {resp_hi_d, resp_lo_d} = product;
        end
      end
      MD_ST_DIV: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (div_done_c) begin
          state_d   = MD_ST_DONE;
          resp_id_d = req_q.id;
          resp_hi_d = div_rem_c;
          resp_lo_d = div_quo_c;
        end
      end
      MD_ST_DONE: begin
        if (resp_ready) state_d = MD_ST_IDLE;
      end
      default: state_d = MD_ST_IDLE;
    endcase
    // flush discards whatever is in flight, including a result being handed over
    if (flush) begin
      state_d   = MD_ST_IDLE;
      cnt_d     = '0;
      resp_id_d = resp_id_q;
      resp_hi_d = resp_hi_q;
      resp_lo_d = resp_lo_q;
    end
    busy_d       = (state_d != MD_ST_IDLE);
    resp_valid_d = (state_d == MD_ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= MD_ST_IDLE;
      cnt_q        <= '0;
      req_q        <= '0;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_hi_q    <= '0;
      resp_lo_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      busy_q       <= busy_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_hi_q    <= resp_hi_d;
      resp_lo_q    <= resp_lo_d;
    end
  end

  assign busy       = busy_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_hi    = resp_hi_q;
  assign resp_lo    = resp_lo_q;

endmodule

// File: tb/tb_md_sched.sv
// Directed self-checking bench for md_sched with hand-computed expectations.
module tb_md_sched;
  import md_sched_pkg::*;

  logic        clk;
  logic        reset;
  logic        flush;
  logic [1:0]  req_valid;
  logic [3:0]  req_op;
  logic [63:0] req_src1;
  logic [63:0] req_src2;
  logic [1:0]  req_ready;
  logic        busy;
  logic        resp_valid;
  logic        resp_id;
  logic [31:0] resp_hi;
  logic [31:0] resp_lo;
  logic        resp_ready;

  int checks = 0;
  int errors = 0;
  int n;

  md_sched #(.MUL_LAT(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_src1   (req_src1),
    .req_src2   (req_src2),
    .req_ready  (req_ready),
    .busy       (busy),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_hi    (resp_hi),
    .resp_lo    (resp_lo),
    .resp_ready (resp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ticks through the fire edge, then counts edges until resp_valid (bounded)
  task automatic wait_resp(input logic [1:0] keep, output int cnt);
    tick();
    cnt = 1;
    req_valid = req_valid & keep;
    while (!resp_valid && cnt < 100) begin
      tick();
      cnt++;
    end
  endtask

  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                       input int lat);
    int c;
    req_valid = 2'b01;
    req_op    = {2'b00, op};
    req_src1  = {32'd0, a};
    req_src2  = {32'd0, b};
    #1;
    chk({tag, "_rdy"}, 64'(req_ready), 64'(2'b01));
    wait_resp(2'b00, c);
    chk({tag, "_lat"}, 64'(c), 64'(lat));
    chk({tag, "_hi"}, 64'(resp_hi), 64'(hi));
    chk({tag, "_lo"}, 64'(resp_lo), 64'(lo));
    chk({tag, "_id"}, 64'(resp_id), 64'(0));
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk({tag, "_rv_clr"}, 64'(resp_valid), 64'(0));
  endtask

  initial begin
    reset      = 1'b1;
    flush      = 1'b0;
    req_valid  = 2'b00;
    req_op     = 4'h0;
    req_src1   = 64'h0;
    req_src2   = 64'h0;
    resp_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_rv", 64'(resp_valid), 64'(0));
    chk("rst_id", 64'(resp_id), 64'(0));
    chk("rst_hi", 64'(resp_hi), 64'(0));
    chk("rst_lo", 64'(resp_lo), 64'(0));
    chk("rst_rdy", 64'(req_ready), 64'(0));

    // signed multiply -2 * 3
    do_op("mult", MD_OP_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 2);

    // both pipes request; pipe 0 divides, pipe 1 stalls until the handshake
    req_valid = 2'b11;
    req_op    = {MD_OP_MULTU, MD_OP_DIVU};
    req_src1  = {32'd5, 32'd100};
    req_src2  = {32'd6, 32'd7};
    #1;
    chk("arb_rdy", 64'(req_ready), 64'(2'b01));
    wait_resp(2'b10, n);
    chk("arb_lat", 64'(n), 64'(33));
    chk("arb_lo", 64'(resp_lo), 64'(14));
    chk("arb_hi", 64'(resp_hi), 64'(2));
    chk("arb_id", 64'(resp_id), 64'(0));
    chk("arb_stall_rdy", 64'(req_ready), 64'(0));
    resp_ready = 1'b1;
    #1;
    chk("arb_hs_rdy", 64'(req_ready), 64'(0));
    tick();
    resp_ready = 1'b0;
    chk("arb_p1_rdy", 64'(req_ready), 64'(2'b10));
    wait_resp(2'b00, n);
    chk("p1_lat", 64'(n), 64'(2));
    chk("p1_lo", 64'(resp_lo), 64'(30));
    chk("p1_hi", 64'(resp_hi), 64'(0));
    chk("p1_id", 64'(resp_id), 64'(1));
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    do_op("div_neg", MD_OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    do_op("div_ovf", MD_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33);
    do_op("divu_z", MD_OP_DIVU, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF, 33);
    do_op("div_z", MD_OP_DIV, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7, 32'hFFFF_FFFF, 33);

    // flush a divide ten cycles in
    req_valid = 2'b01;
    req_op    = {2'b00, MD_OP_DIV};
    req_src1  = {32'd0, 32'd1000};
    req_src2  = {32'd0, 32'd3};
    tick();
    req_valid = 2'b00;
    repeat (9) tick();
    chk("fl_busy_pre", 64'(busy), 64'(1));
    flush     = 1'b1;
    req_valid = 2'b01;
    #1;
    chk("fl_rdy", 64'(req_ready), 64'(0));
    req_valid = 2'b00;
    tick();
    flush = 1'b0;
    chk("fl_busy", 64'(busy), 64'(0));
    chk("fl_rv", 64'(resp_valid), 64'(0));
    repeat (30) tick();
    chk("fl_rv_late", 64'(resp_valid), 64'(0));
    do_op("mulu_after", MD_OP_MULTU, 32'd2, 32'd2, 32'd0, 32'd4, 2);

    // result held in DONE while a new request waits
    req_valid = 2'b01;
    req_op    = {2'b00, MD_OP_MULT};
    req_src1  = {32'd0, 32'd7};
    req_src2  = {32'd0, 32'hFFFF_FFFF};
    #1;
    wait_resp(2'b00, n);
    chk("hold_lat", 64'(n), 64'(2));
    req_valid = 2'b11;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("hold_rdy", 64'(req_ready), 64'(0));
      chk("hold_rv", 64'(resp_valid), 64'(1));
      chk("hold_hi", 64'(resp_hi), 64'(32'hFFFF_FFFF));
      chk("hold_lo", 64'(resp_lo), 64'(32'hFFFF_FFF9));
      tick();
    end
    req_valid  = 2'b00;
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("hold_rv_clr", 64'(resp_valid), 64'(0));
    chk("hold_busy_clr", 64'(busy), 64'(0));

    // flush coinciding with the handshake
    req_valid = 2'b01;
    req_op    = {2'b00, MD_OP_MULTU};
    req_src1  = {32'd0, 32'd3};
    req_src2  = {32'd0, 32'd5};
    #1;
    wait_resp(2'b00, n);
    chk("flhs_lo", 64'(resp_lo), 64'(15));
    flush      = 1'b1;
    resp_ready = 1'b1;
    tick();
    flush      = 1'b0;
    resp_ready = 1'b0;
    chk("flhs_rv", 64'(resp_valid), 64'(0));
    chk("flhs_busy", 64'(busy), 64'(0));
    req_valid = 2'b01;
    #1;
    chk("flhs_rdy", 64'(req_ready), 64'(2'b01));
    req_valid = 2'b00;

    // reset in the middle of a multiply
    req_valid = 2'b01;
    req_op    = {2'b00, MD_OP_MULT};
    req_src1  = {32'd0, 32'd3};
    req_src2  = {32'd0, 32'd4};
    tick();
    req_valid = 2'b00;
    chk("rmid_busy_pre", 64'(busy), 64'(1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rmid_busy", 64'(busy), 64'(0));
    chk("rmid_rv", 64'(resp_valid), 64'(0));
    chk("rmid_id", 64'(resp_id), 64'(0));
    chk("rmid_hi", 64'(resp_hi), 64'(0));
    chk("rmid_lo", 64'(resp_lo), 64'(0));
    repeat (5) tick();
    chk("rmid_rv_late", 64'(resp_valid), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
